fp32_dwt_tap_feeder: RTL and testbench

- Upstream operand sequencer for the FP32 sym4 wavelet decomposition datapath.
- Accepts a stream of FP32 samples into an NTAPS-deep delay line and decimates by 2.
- For every second accepted sample it issues 2*NTAPS (sample, coefficient) pairs back-to-back into the pipelined FP32 multiplier: the lowpass bank first, then the highpass bank.
- Tap and band tags travel alongside each pair so the downstream accumulator can frame each output.

---
 rtl/fp32_dwt_tap_feeder.sv | 199 +++++++++++++++++++
 tb/tb_fp32_dwt_tap_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_dwt_tap_feeder.sv
// Operand sequencer for the FP32 sym4 wavelet datapath: an NTAPS-deep delay line,
// decimation by 2, and a lowpass-then-highpass burst of (sample, coefficient) pairs.
module fp32_dwt_tap_feeder #(
    parameter int NTAPS = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [31:0]      din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             coef_we,
    input  logic             coef_band,
    input  logic [IDX_W-1:0] coef_addr,
    input  logic [31:0]      coef_data,
    output logic             coef_err,
    output logic [31:0]      dina,
    output logic [31:0]      dinb,
    output logic             valid_dout,
    output logic [IDX_W-1:0] tap_idx,
    output logic             band,
    output logic             last
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NTAPS - 1);

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [IDX_W-1:0] tap_q, tap_d;
    logic             band_q, band_d;
    logic             coef_err_q, coef_err_d;

    logic [31:0]      x_q    [NTAPS];
    logic [31:0]      coef_q [2][NTAPS];

    logic [31:0]      dina_q, dina_d;
    logic [31:0]      dinb_q, dinb_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] tap_idx_q, tap_idx_d;
    logic             band_out_q, band_out_d;
    logic             last_q, last_d;

    logic             accept;
    logic             coef_wr;

    assign din_ready = (state_q == S_IDLE);
    assign accept    = din_valid && (state_q == S_IDLE) && !clr;
    // Coefficient writes are gated on the registered state only, so a write in the
    // same cycle as the accept that starts a burst still lands before the first pair.
    assign coef_wr   = coef_we && (state_q == S_IDLE);

    // Control: phase, burst counters, state
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tap_d   = tap_q;
        band_d  = band_q;
        if (clr) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
            tap_d   = '0;
            band_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        phase_d = ~phase_q;
                        if (phase_q) begin
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (tap_q == LAST_TAP) begin
                        tap_d = '0;
                        if (band_q) begin
                            band_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            band_d = 1'b1;
                        end
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        coef_err_d = coef_err_q;
        if (clr) begin
            coef_err_d = 1'b0;
        end else if (coef_we && (state_q == S_ISSUE)) begin
            coef_err_d = 1'b1;
        end
    end

    // Output pair registers; payload holds while no pair is being issued
    always_comb begin
        valid_d    = !clr && (state_q == S_ISSUE);
        dina_d     = dina_q;
        dinb_d     = dinb_q;
        tap_idx_d  = tap_idx_q;
        band_out_d = band_out_q;
        last_d     = last_q;
        if (valid_d) begin
            dina_d     = x_q[tap_q];
            dinb_d     = coef_q[band_q][tap_q];
            tap_idx_d  = tap_q;
            band_out_d = band_q;
            last_d     = (tap_q == LAST_TAP);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            tap_q      <= '0;
            band_q     <= 1'b0;
            coef_err_q <= 1'b0;
            dina_q     <= '0;
            dinb_q     <= '0;
            valid_q    <= 1'b0;
            tap_idx_q  <= '0;
            band_out_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tap_q      <= tap_d;
            band_q     <= band_d;
            coef_err_q <= coef_err_d;
            dina_q     <= dina_d;
            dinb_q     <= dinb_d;
            valid_q    <= valid_d;
            tap_idx_q  <= tap_idx_d;
            band_out_q <= band_out_d;
            last_q     <= last_d;
        end
    end

    // Delay line: x[0] is the newest sample
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_delay
        logic [31:0] x_d;
        always_comb begin
            x_d = x_q[gi];
            if (clr) begin
                x_d = '0;
            end else if (accept) begin
                if (gi == 0) begin
                    x_d = din;
                end else begin
                    x_d = x_q[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                x_q[gi] <= '0;
            end else begin
                x_q[gi] <= x_d;
            end
        end
    end

    // Coefficient banks survive clr; only rstn clears them
    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    coef_q[gb][gi] <= '0;
                end else if (coef_wr && (coef_band == 1'(gb)) &&
                             (coef_addr == IDX_W'(gi))) begin
                    coef_q[gb][gi] <= coef_data;
                end
            end
        end
    end

    assign coef_err   = coef_err_q;
    assign dina       = dina_q;
    assign dinb       = dinb_q;
    assign valid_dout = valid_q;
    assign tap_idx    = tap_idx_q;
    assign band       = band_out_q;
    assign last       = last_q;

endmodule

// File: tb/tb_fp32_dwt_tap_feeder.sv
// Scoreboard bench for fp32_dwt_tap_feeder: a sample-history model predicts every
// issued pair, handshake level and error flag; a negedge monitor compares.
module tb_fp32_dwt_tap_feeder;

    localparam int N = 8;
    localparam int W = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic [31:0]   din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          coef_we = 1'b0;
    logic          coef_band = 1'b0;
    logic [W-1:0]  coef_addr = '0;
    logic [31:0]   coef_data = '0;
    logic          coef_err;
    logic [31:0]   dina, dinb;
    logic          valid_dout;
    logic [W-1:0]  tap_idx;
    logic          band, last;

    fp32_dwt_tap_feeder #(.NTAPS(N), .IDX_W(W)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .coef_we(coef_we), .coef_band(coef_band), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(coef_err),
        .dina(dina), .dinb(dinb), .valid_dout(valid_dout),
        .tap_idx(tap_idx), .band(band), .last(last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  a;
        logic [31:0]  b;
        logic [W-1:0] k;
        logic         bnd;
        logic         lst;
    } pair_t;

    // Reference model: sample history, coefficient tables, burst bookkeeping
    logic [31:0] m_hist [N];
    logic [31:0] m_coef [2][N];
    bit          m_phase;
    int          m_busy;      // pairs still owed by the current burst
    bit          m_err;
    bit          m_valid;     // a pair is expected on the outputs this cycle
    bit          m_accepted;
    pair_t       exq [$];

    int n_pass = 0;
    int n_total = 0;
    int n_seq_pairs = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_hist[k] = '0;
            m_coef[0][k] = '0;
            m_coef[1][k] = '0;
        end
        m_phase = 0; m_busy = 0; m_err = 0; m_valid = 0;
        exq.delete();
    endtask

    // Apply one clock edge's worth of specification rules to the model
    task automatic model_edge(input bit v, input logic [31:0] d, input bit we,
                              input bit wb, input logic [W-1:0] wa,
                              input logic [31:0] wd, input bit c);
        bit ready = (m_busy == 0);
        m_accepted = 0;
        if (we && ready) m_coef[wb][wa] = wd;
        if (c) begin
            for (int k = 0; k < N; k++) m_hist[k] = '0;
            m_phase = 0; m_busy = 0; m_err = 0; m_valid = 0;
            exq.delete();
            return;
        end
        if (we && !ready) m_err = 1;
        m_valid = !ready;
        if (!ready) m_busy--;
        if (v && ready) begin
            m_accepted = 1;
            for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = d;
            if (m_phase) begin
                for (int b = 0; b < 2; b++)
                    for (int k = 0; k < N; k++)
                        exq.push_back('{a: m_hist[k], b: m_coef[b][k], k: W'(k),
                                        bnd: 1'(b), lst: (k == N - 1)});
                m_busy = 2 * N;
            end
            m_phase = !m_phase;
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit we, input bit wb,
                        input logic [W-1:0] wa, input logic [31:0] wd, input bit c);
        din_valid = v; din = d; coef_we = we; coef_band = wb;
        coef_addr = wa; coef_data = wd; clr = c;
        @(posedge clk);
        model_edge(v, d, we, wb, wa, wd, c);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic send(input logic [31:0] d);
        int guard = 0;
        do begin
            step(1, d, 0, 0, '0, '0, 0);
            guard++;
        end while (!m_accepted && guard < 100);
        if (!m_accepted) chk("send_timeout", 0, 1);
    endtask

    task automatic wcoef(input bit b, input int k, input logic [31:0] v);
        step(0, '0, 1, b, W'(k), v, 0);
    endtask

    task automatic do_reset();
        #1;
        rstn = 1'b0;
        din_valid = 0; coef_we = 0; clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: compares handshake, error flag, and every issued pair to the scoreboard
    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            pair_t e, g;
            chk("din_ready", 128'(din_ready), 128'(m_busy == 0));
            chk("coef_err", 128'(coef_err), 128'(m_err));
            chk("valid_dout", 128'(valid_dout), 128'(m_valid));
            if (m_valid) begin
                if (exq.size() == 0) begin
                    chk("scoreboard_underflow", 0, 1);
                end else begin
                    e = exq.pop_front();
                    g = '{a: dina, b: dinb, k: tap_idx, bnd: band, lst: last};
                    chk("pair", 128'(g), 128'(e));
                    n_seq_pairs++;
                    if (e.lst && e.bnd)
                        $display("burst done at t=%0t last pair a=%08h b=%08h",
                                 $time, g.a, g.b);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_dina", 128'(dina), 0);
        chk("rst_dinb", 128'(dinb), 0);
        chk("rst_tap", 128'(tap_idx), 0);
        chk("rst_band", 128'(band), 0);
        chk("rst_last", 128'(last), 0);
        chk("rst_valid", 128'(valid_dout), 0);
        chk("rst_err", 128'(coef_err), 0);
        chk("rst_ready", 128'(din_ready), 1);
        @(negedge clk);
        mon_en = 1;
        idle(4);

        // Basic sequence
        for (int k = 0; k < N; k++) wcoef(0, k, 32'h3F800000);
        for (int k = 0; k < N; k++) wcoef(1, k, 32'hBF800000);
        send(32'h40000000);
        send(32'h40400000);
        idle(20);
        $display("basic sequence: %0d pairs seen", n_seq_pairs);

        // Backpressure: six distinct samples offered back-to-back
        for (int i = 0; i < 6; i++) send(32'h41000000 + 32'(i));
        idle(20);
        $display("backpressure: %0d pairs seen", n_seq_pairs);

        // Coefficient write during a burst is dropped and flagged
        send(32'h3E000000);
        send(32'h3E800000);
        idle(4);
        wcoef(0, 2, 32'h12345678);
        idle(14);
        send(32'h3F000000);
        send(32'h3F400000);
        idle(20);
        step(0, '0, 0, 0, '0, '0, 1);
        idle(2);

        // clr in the middle of a burst
        send(32'h7F800000);
        send(32'h7FC00001);
        idle(9);
        step(0, '0, 0, 0, '0, '0, 1);
        idle(2);
        send(32'h00000001);
        send(32'h80000001);
        idle(20);

        // clr with a sample presented in the same cycle
        step(1, 32'hDEADBEEF, 0, 0, '0, '0, 1);
        send(32'h11111111);
        send(32'h22222222);
        idle(20);

        // Asynchronous reset in the middle of a burst
        send(32'h33333333);
        send(32'h44444444);
        idle(5);
        do_reset();
        @(negedge clk);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 2 * N; i++) wcoef(i / N, i % N, $urandom);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 8) == 0,
                 1'($urandom), W'($urandom), $urandom, ($urandom % 250) == 0);
        end
        idle(2 * N + 4);

        chk("scoreboard_empty", 128'(exq.size()), 0);
        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end

endmodule
